bus_switch_arb: RTL and testbench
=================================

# bus_switch_arb

Registered, parametrised multi-channel bus switch: the successor to the 1-bit switch in the MEMORY series. It selects one of `CHANNELS` enabled `WIDTH`-bit inputs per clock and drives it onto a single output bus one cycle later. Selection uses fixed-priority or round-robin arbitration. A conflict flag reports contention. The block sits between multiple memory/register producers and a shared data bus.

## Interface
- `WIDTH`, default 8: data width per channel; must be ≥1.
- `CHANNELS`, default 4: number of input channels; must be ≥2.
- `ARB_MODE`, default 0: 0 = fixed priority, lowest index wins; 1 = round-robin.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_data`  in  `CHANNELS*WIDTH`  channel k occupies bits `[k*WIDTH +: WIDTH]`.
- `in_en`  in  `CHANNELS`  per-channel switch enable; bit k requests channel k.
- `out_data`  out  `WIDTH`  registered selected data.
- `out_valid`  out  1  registered; 1 when some channel was granted in the previous cycle.
- `out_sel`  out  `$clog2(CHANNELS)`  registered index of the granted channel.
- `grant`  out  `CHANNELS`  registered one-hot grant; all-zero when idle.
- `conflict`  out  1  registered; 1 when ≥2 `in_en` bits were high in the previous cycle.

## Operation
- Each cycle, the arbiter picks at most one channel from the asserted `in_en` bits.
- **Fixed priority (`ARB_MODE`=0):** lowest asserted index wins.
- **Round-robin (`ARB_MODE`=1):** internal pointer `ptr` (width of `out_sel`) names the highest-priority channel.
  - Search order is `ptr`, `ptr+1`, … mod `CHANNELS`.
  - After a grant to channel k, `ptr` ← (k+1) mod `CHANNELS`.
  - Wrap-around: a grant to `CHANNELS-1` sets `ptr` to 0.
  - `ptr` is unchanged on idle cycles.
  - Non-power-of-2 `CHANNELS` is supported; `ptr` never exceeds `CHANNELS-1`.
- **Grant:** `out_data` ← granted channel's data, `out_sel` ← k, `grant` ← one-hot(k), `out_valid` ← 1.
- **Idle (`in_en` all zero):** `out_valid` ← 0, `grant` ← 0, `out_sel` ← 0; `out_data` is handled per Configuration.
- `conflict` ← 1 iff popcount(`in_en`) ≥ 2, independent of mode. The winner is still granted normally; losers are dropped, with no queueing.
- `in_data` of non-granted channels is ignored.

## Timing
- Latency: 1 cycle from `in_en`/`in_data` sampled at edge N to outputs valid after edge N.
- No back-pressure; a new selection is made every cycle, and back-to-back grants are allowed.
- Reset (asynchronous assert, while `rst_n`=0), all outputs immediately:
  - `out_data`=0, `out_valid`=0, `out_sel`=0, `grant`=0, `conflict`=0, `ptr`=0.
- Reset mid-operation discards the in-flight selection.
- Release is synchronous to `clk`; the first sample occurs on the first rising edge with `rst_n`=1.
- Combinational paths from inputs to outputs are forbidden; every output is a flop.

## Configuration
- Macro `BUS_SWITCH_HOLD_EN`.
- **Defined:** on an idle cycle, `out_data` retains its last granted value. The bus behaves like a latched switch.
- **Undefined:** on an idle cycle, `out_data` ← 0 ("no value" is zero).
- `out_valid`, `grant`, `out_sel` and `conflict` behave identically in both builds.

## Test plan
- **Reset:**
  - Drive `rst_n`=0 mid-cycle with `in_en`=4'b0001 active → all outputs 0 immediately, without waiting for an edge.
  - Release → the first grant appears one edge after release.
- **Single channel:** WIDTH=8, CHANNELS=4. `in_en`=4'b0100, ch2 data=8'hA5 → next cycle:
  - `out_data`=8'hA5, `out_sel`=2, `grant`=4'b0100, `out_valid`=1, `conflict`=0.
- **Fixed priority:** `ARB_MODE`=0, `in_en`=4'b1010 held 3 cycles → ch1 granted every cycle, with `conflict`=1 every cycle.
- **Round-robin wrap:** `ARB_MODE`=1, `in_en`=4'b1111 held 5 cycles → `out_sel` sequence 0,1,2,3,0.
  - Then `in_en`=0 for 1 cycle and 4'b1001 → grant ch1's successor rule: ptr=1, so ch3 is granted first, then ch0.
- **Idle handling:** grant 8'h3C, then `in_en`=0 → `out_valid`=0, `grant`=0.
  - `out_data`=8'h3C with `BUS_SWITCH_HOLD_EN` defined; 8'h00 without it.
- **Non-power-of-2:** CHANNELS=3, `ARB_MODE`=1, all enabled for 4 cycles → `out_sel` 0,1,2,0; `ptr` never equals 3.

Source files
------------

// File: rtl/bus_switch_arb.sv
// Multi-channel registered bus switch: picks one enabled channel per cycle (fixed-priority or round-robin).
// Latency: 1 cycle from in_en/in_data sampled to out_* registered; all outputs are flops.
// Backpressure: none; a new selection every cycle, losing requests are dropped. Macro BUS_SWITCH_HOLD_EN holds out_data when idle.
module bus_switch_arb #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int ARB_MODE = 0,
    localparam int SW      = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_en,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    output logic [SW-1:0]             out_sel,
    output logic [CHANNELS-1:0]       grant,
    output logic                      conflict
);

    // Round-robin pointer: highest-priority channel for the next search.
    logic [SW-1:0]       ptr;

    logic                found;
    logic [SW-1:0]       win;
    logic [SW:0]         base_w;
    logic [SW:0]         idx_w;
    logic [CHANNELS-1:0] gnt_nxt;
    logic [WIDTH-1:0]    sel_data;
    logic [SW-1:0]       ptr_nxt;
    logic                conflict_nxt;

    // Search CHANNELS positions starting at base (ptr in RR mode, 0 otherwise), wrapping mod CHANNELS.
    // The extra index bit keeps base+i from overflowing before the wrap subtraction, so
    // non-power-of-2 channel counts never produce an out-of-range index.
    always_comb begin
        found  = 1'b0;
        win    = '0;
        idx_w  = '0;
        base_w = (ARB_MODE == 1) ? {1'b0, ptr} : '0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx_w = base_w + (SW+1)'(i);
            if (idx_w >= (SW+1)'(CHANNELS)) begin
                idx_w = idx_w - (SW+1)'(CHANNELS);
            end
            if (!found && in_en[idx_w[SW-1:0]]) begin
                found = 1'b1;
                win   = idx_w[SW-1:0];
            end
        end
    end

    // One-hot grant, AND-OR data mux over the grant, next pointer and contention flag.
    always_comb begin
        gnt_nxt  = found ? (CHANNELS'(1) << win) : '0;
        sel_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (gnt_nxt[k]) begin
                sel_data = sel_data | in_data[k*WIDTH +: WIDTH];
            end
        end
        ptr_nxt      = (win == SW'(CHANNELS-1)) ? '0 : win + 1'b1;
        // Two or more bits set iff clearing the lowest set bit leaves something behind.
        conflict_nxt = |(in_en & (in_en - CHANNELS'(1)));
    end

    // Register the selection; pointer only advances on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sel   <= '0;
            grant     <= '0;
            conflict  <= 1'b0;
            ptr       <= '0;
        end else begin
            out_valid <= found;
            out_sel   <= found ? win : '0;
            grant     <= gnt_nxt;
            conflict  <= conflict_nxt;
            if (found) begin
                ptr <= ptr_nxt;
            end
`ifdef BUS_SWITCH_HOLD_EN
            if (found) begin
                out_data <= sel_data;
            end
`else
            out_data <= found ? sel_data : '0;
`endif
        end
    end

endmodule

// File: tb/tb_bus_switch_arb.sv
// Directed bench for bus_switch_arb: fixed-priority, 4-channel round-robin and 3-channel round-robin instances.
// Checks are taken 1 time unit after each rising edge; inputs change right after the check.
// Each scenario is its own task, called in sequence from one initial block.
module tb_bus_switch_arb;

`ifdef BUS_SWITCH_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic clk;
    logic rst_n;

    // Fixed-priority 4-channel instance
    logic [31:0] f_data;
    logic [3:0]  f_en;
    logic [7:0]  f_out;
    logic        f_vld;
    logic [1:0]  f_sel;
    logic [3:0]  f_gnt;
    logic        f_conf;

    // Round-robin 4-channel instance
    logic [31:0] r_data;
    logic [3:0]  r_en;
    logic [7:0]  r_out;
    logic        r_vld;
    logic [1:0]  r_sel;
    logic [3:0]  r_gnt;
    logic        r_conf;

    // Round-robin 3-channel instance
    logic [23:0] t_data;
    logic [2:0]  t_en;
    logic [7:0]  t_out;
    logic        t_vld;
    logic [1:0]  t_sel;
    logic [2:0]  t_gnt;
    logic        t_conf;

    int n_checks;
    int n_fail;

    bus_switch_arb #(.WIDTH(8), .CHANNELS(4), .ARB_MODE(0)) dut_f (
        .clk(clk), .rst_n(rst_n), .in_data(f_data), .in_en(f_en),
        .out_data(f_out), .out_valid(f_vld), .out_sel(f_sel), .grant(f_gnt), .conflict(f_conf)
    );

    bus_switch_arb #(.WIDTH(8), .CHANNELS(4), .ARB_MODE(1)) dut_r (
        .clk(clk), .rst_n(rst_n), .in_data(r_data), .in_en(r_en),
        .out_data(r_out), .out_valid(r_vld), .out_sel(r_sel), .grant(r_gnt), .conflict(r_conf)
    );

    bus_switch_arb #(.WIDTH(8), .CHANNELS(3), .ARB_MODE(1)) dut_t (
        .clk(clk), .rst_n(rst_n), .in_data(t_data), .in_en(t_en),
        .out_data(t_out), .out_valid(t_vld), .out_sel(t_sel), .grant(t_gnt), .conflict(t_conf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] exp;
        #2;
        n_checks++;
        if ({f_vld, f_sel, f_gnt, f_conf, f_out} !== 16'h0 ||
            {r_vld, r_sel, r_gnt, r_conf, r_out} !== 16'h0 ||
            {t_vld, t_sel, t_gnt, t_conf, t_out} !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_state: f=%h r=%h t=%h required all 0",
                     {f_vld, f_sel, f_gnt, f_conf, f_out}, {r_vld, r_sel, r_gnt, r_conf, r_out},
                     {t_vld, t_sel, t_gnt, t_conf, t_out});
        end
        @(negedge clk);
        rst_n  = 1'b1;
        f_en   = 4'b0001;
        f_data = 32'h0000_0011;
        tick();
        exp = {1'b1, 2'd0, 4'b0001, 1'b0, 8'h11};
        n_checks++;
        if ({f_vld, f_sel, f_gnt, f_conf, f_out} !== exp) begin
            n_fail++;
            $display("FAIL pre_reset_grant: got %h required %h", {f_vld, f_sel, f_gnt, f_conf, f_out}, exp);
        end
        // Assert reset mid-cycle with the request still active
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({f_vld, f_sel, f_gnt, f_conf, f_out} !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset: got %h required 0000", {f_vld, f_sel, f_gnt, f_conf, f_out});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({f_vld, f_sel, f_gnt, f_conf, f_out} !== 16'h0) begin
            n_fail++;
            $display("FAIL release_no_edge: got %h required 0000", {f_vld, f_sel, f_gnt, f_conf, f_out});
        end
        tick();
        n_checks++;
        if ({f_vld, f_sel, f_gnt, f_conf, f_out} !== exp) begin
            n_fail++;
            $display("FAIL first_grant_after_release: got %h required %h", {f_vld, f_sel, f_gnt, f_conf, f_out}, exp);
        end
        f_en = 4'b0000;
    endtask

    task automatic test_single_and_back_to_back();
        logic [15:0] exp;
        f_data = 32'h77A5_5566;
        f_en   = 4'b0100;
        tick();
        exp = {1'b1, 2'd2, 4'b0100, 1'b0, 8'hA5};
        n_checks++;
        if ({f_vld, f_sel, f_gnt, f_conf, f_out} !== exp) begin
            n_fail++;
            $display("FAIL single_ch2: got %h required %h", {f_vld, f_sel, f_gnt, f_conf, f_out}, exp);
        end
        f_en = 4'b1000;
        tick();
        exp = {1'b1, 2'd3, 4'b1000, 1'b0, 8'h77};
        n_checks++;
        if ({f_vld, f_sel, f_gnt, f_conf, f_out} !== exp) begin
            n_fail++;
            $display("FAIL back_to_back_ch3: got %h required %h", {f_vld, f_sel, f_gnt, f_conf, f_out}, exp);
        end
    endtask

    task automatic test_fixed_priority();
        logic [15:0] exp;
        f_en = 4'b1010;
        exp  = {1'b1, 2'd1, 4'b0010, 1'b1, 8'h55};
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if ({f_vld, f_sel, f_gnt, f_conf, f_out} !== exp) begin
                n_fail++;
                $display("FAIL fixed_prio cycle %0d: got %h required %h", c, {f_vld, f_sel, f_gnt, f_conf, f_out}, exp);
            end
        end
    endtask

    task automatic test_idle();
        logic [15:0] exp;
        f_data = 32'h0000_003C;
        f_en   = 4'b0001;
        tick();
        exp = {1'b1, 2'd0, 4'b0001, 1'b0, 8'h3C};
        n_checks++;
        if ({f_vld, f_sel, f_gnt, f_conf, f_out} !== exp) begin
            n_fail++;
            $display("FAIL idle_setup_grant: got %h required %h", {f_vld, f_sel, f_gnt, f_conf, f_out}, exp);
        end
        f_en = 4'b0000;
        exp  = {1'b0, 2'd0, 4'b0000, 1'b0, (HOLD ? 8'h3C : 8'h00)};
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if ({f_vld, f_sel, f_gnt, f_conf, f_out} !== exp) begin
                n_fail++;
                $display("FAIL idle cycle %0d: got %h required %h", c, {f_vld, f_sel, f_gnt, f_conf, f_out}, exp);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] exp;
        logic [1:0]  s;
        r_data = 32'h4433_2211;
        r_en   = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            s = 2'(c % 4);
            tick();
            exp = {1'b1, s, (4'b0001 << s), 1'b1, 8'h11 * (8'(s) + 8'd1)};
            n_checks++;
            if ({r_vld, r_sel, r_gnt, r_conf, r_out} !== exp) begin
                n_fail++;
                $display("FAIL rr_wrap cycle %0d: got %h required %h", c, {r_vld, r_sel, r_gnt, r_conf, r_out}, exp);
            end
        end
        r_en = 4'b0000;
        tick();
        exp = {1'b0, 2'd0, 4'b0000, 1'b0, (HOLD ? 8'h11 : 8'h00)};
        n_checks++;
        if ({r_vld, r_sel, r_gnt, r_conf, r_out} !== exp) begin
            n_fail++;
            $display("FAIL rr_idle: got %h required %h", {r_vld, r_sel, r_gnt, r_conf, r_out}, exp);
        end
        n_checks++;
        if (dut_r.ptr !== 2'd1) begin
            n_fail++;
            $display("FAIL rr_ptr_hold_idle: got %0d required 1", dut_r.ptr);
        end
        r_en = 4'b1001;
        tick();
        exp = {1'b1, 2'd3, 4'b1000, 1'b1, 8'h44};
        n_checks++;
        if ({r_vld, r_sel, r_gnt, r_conf, r_out} !== exp) begin
            n_fail++;
            $display("FAIL rr_1001_first: got %h required %h", {r_vld, r_sel, r_gnt, r_conf, r_out}, exp);
        end
        tick();
        exp = {1'b1, 2'd0, 4'b0001, 1'b1, 8'h11};
        n_checks++;
        if ({r_vld, r_sel, r_gnt, r_conf, r_out} !== exp) begin
            n_fail++;
            $display("FAIL rr_1001_second: got %h required %h", {r_vld, r_sel, r_gnt, r_conf, r_out}, exp);
        end
        r_en = 4'b0000;
    endtask

    task automatic test_non_pow2();
        logic [14:0] exp;
        logic [1:0]  s;
        logic [1:0]  p;
        logic [7:0]  d;
        t_data = 24'hCC_BB_AA;
        t_en   = 3'b111;
        for (int c = 0; c < 4; c++) begin
            s = 2'(c % 3);
            p = 2'((c + 1) % 3);
            d = (s == 2'd0) ? 8'hAA : (s == 2'd1) ? 8'hBB : 8'hCC;
            tick();
            exp = {1'b1, s, (3'b001 << s), 1'b1, d};
            n_checks++;
            if ({t_vld, t_sel, t_gnt, t_conf, t_out} !== exp) begin
                n_fail++;
                $display("FAIL np2 cycle %0d: got %h required %h", c, {t_vld, t_sel, t_gnt, t_conf, t_out}, exp);
            end
            n_checks++;
            if (dut_t.ptr !== p) begin
                n_fail++;
                $display("FAIL np2_ptr cycle %0d: got %0d required %0d", c, dut_t.ptr, p);
            end
        end
        t_en = 3'b000;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        f_data   = '0;
        f_en     = '0;
        r_data   = '0;
        r_en     = '0;
        t_data   = '0;
        t_en     = '0;
        test_reset();
        test_single_and_back_to_back();
        test_fixed_priority();
        test_idle();
        test_round_robin();
        test_non_pow2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
